// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with start/ready/done handshake
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    // Latched operation context; acc holds {hi, lo}: product for multiply,
    // {remainder, dividend/quotient} for divide.
    logic [2:0]        op;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   mb;
    logic [2*XLEN-1:0] acc;
    logic              neg;
    logic [CW-1:0]     cnt;

    // Operand decode at the accept edge
    logic              a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              is_div, neg_in, div_zero, ovf, special;
    logic [XLEN-1:0]   special_res;

    assign a_signed = (funct3 != 3'b011) && !(funct3[2] && funct3[0]);
    assign b_signed = a_signed && (funct3 != 3'b010);
    assign sa       = a_signed && a[XLEN-1];
    assign sb       = b_signed && b[XLEN-1];
    assign mag_a    = sa ? -a : a;
    assign mag_b    = sb ? -b : b;
    assign is_div   = funct3[2];
    // Remainder takes the dividend's sign; everything else the XOR of both.
    assign neg_in   = (is_div && funct3[1]) ? sa : (sa ^ sb);
    assign div_zero = is_div && (b == '0);
    assign ovf      = is_div && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign special  = div_zero || ovf;
    assign special_res = div_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);

    // One iteration step: shift-add multiply or restoring divide
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_trial;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo, rem, final_res;
    logic              last;

    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mb} : '0);
    assign mul_next  = {mul_sum, acc[XLEN-1:1]};
    assign div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_ge    = div_trial >= {1'b0, mb};
    assign div_diff  = div_trial[XLEN-1:0] - mb;
    assign div_next  = {(div_ge ? div_diff : div_trial[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    assign acc_next  = op[2] ? div_next : mul_next;
    assign prod_fix  = neg ? -acc_next : acc_next;
    assign quo       = acc_next[XLEN-1:0];
    assign rem       = acc_next[2*XLEN-1:XLEN];
    assign last      = (cnt == CW'(XLEN - 1));

    // Select the finished result from the final iteration value
    always_comb begin
        final_res = '0;
        case (op)
            3'b000:                final_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:        final_res = neg ? -quo : quo;
            default:               final_res = neg ? -rem : rem;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = special ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture at accept, iterate in CALC, publish result on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op     <= '0;
            rd_q   <= '0;
            mb     <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            result <= '0;
            rd_out <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                op   <= funct3;
                rd_q <= rd_in;
                mb   <= mag_b;
                acc  <= {{XLEN{1'b0}}, mag_a};
                neg  <= neg_in;
                cnt  <= '0;
                if (special) begin
                    result <= special_res;
                    rd_out <= rd_in;
                end
            end
        end else if (state == CALC) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (last) begin
                result <= final_res;
                rd_out <= rd_q;
            end
        end
    end

endmodule
